// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage behind the 8-bit ALU.
//   - Accepts ALU results over an in_valid/in_ready handshake.
//   - Holds the architectural carry (C) and overflow (V) flags that feed
//     back to the ALU's CarryIn/OverflowIn.
//   - Resolves BEQZ into a registered one-cycle branch_taken pulse.
//   - Flags illegal encodings with a registered one-cycle illegal pulse.
//   - Queues register-file writes in a 2-entry FIFO.
// Ports:
//   Clk, Reset                    clock, asynchronous active-high reset
//   in_valid / in_ready           ALU result handshake
//   in_ritype, in_op, in_op2      instruction class and opcode
//   in_waddr, in_result           destination register and ALU result
//   in_carry, in_ovf, in_zero     ALU status outputs
//   flag_clr                      synchronous clear of C and V
//   carry_flag, ovf_flag          architectural C and V flags
//   wb_valid / wb_ready           register-file write handshake
//   wb_waddr, wb_wdata            FIFO head entry
//   branch_taken, illegal         registered one-cycle pulses
module alu_writeback #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_ritype,
  input  logic [2:0]    in_op,
  input  logic [1:0]    in_op2,
  input  logic [AW-1:0] in_waddr,
  input  logic [DW-1:0] in_result,
  input  logic          in_carry,
  input  logic          in_ovf,
  input  logic          in_zero,
  input  logic          flag_clr,
  output logic          carry_flag,
  output logic          ovf_flag,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata,
  output logic          branch_taken,
  output logic          illegal
);

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_XOR   = 3'b011,
    OP_MOV   = 3'b100,
    OP_SHIFT = 3'b101,
    OP_GT    = 3'b110,
    OP_ILL   = 3'b111
  } rop_e;

  typedef enum logic [1:0] {
    IOP_BEQZ = 2'b00,
    IOP_LI   = 2'b01,
    IOP_ILL2 = 2'b10,
    IOP_ILL3 = 2'b11
  } iop_e;

  rop_e          rop;
  iop_e          iop;
  logic          accept;
  logic          is_write;
  logic          is_illegal;
  logic          is_branch;
  logic          push;
  logic          pop;

  logic [1:0]    count_q, count_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] addr_q [2];
  logic [DW-1:0] data_q [2];
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          branch_q, branch_d;
  logic          illegal_q, illegal_d;
  logic          head;

  // Decode
  always_comb begin
    rop        = rop_e'(in_op);
    iop        = iop_e'(in_op2);
    in_ready   = (count_q != 2'd2) & ~Reset;
    accept     = in_valid & in_ready;
    if (in_ritype) begin
      is_write   = (iop == IOP_LI);
      is_illegal = (iop == IOP_ILL2) || (iop == IOP_ILL3);
      is_branch  = (iop == IOP_BEQZ);
    end else begin
      is_write   = (rop != OP_ILL);
      is_illegal = (rop == OP_ILL);
      is_branch  = 1'b0;
    end
    push = accept & is_write;
    pop  = (count_q != 2'd0) & wb_ready;
  end

  // Next state for flags, pulses and FIFO bookkeeping.
  // The instruction's own flag write is applied after flag_clr so it wins.
  always_comb begin
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (flag_clr) begin
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end
    if (accept && !in_ritype && rop == OP_SHIFT) carry_d = in_carry;
    if (accept && !in_ritype && rop == OP_ADD)   ovf_d   = in_ovf;

    branch_d  = accept & is_branch & in_zero;
    illegal_d = accept & is_illegal;

    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q   <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      if (push) begin
        addr_q[wr_ptr_q] <= in_waddr;
        data_q[wr_ptr_q] <= in_result;
      end
    end
  end

  // When empty, the slot behind the read pointer is the last popped entry:
  // a push into an empty FIFO always lands at rd_ptr, never behind it.
  always_comb begin
    head         = (count_q != 2'd0) ? rd_ptr_q : ~rd_ptr_q;
    wb_valid     = (count_q != 2'd0);
    wb_waddr     = addr_q[head];
    wb_wdata     = data_q[head];
    carry_flag   = carry_q;
    ovf_flag     = ovf_q;
    branch_taken = branch_q;
    illegal      = illegal_q;
  end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_ritype;
  logic [2:0] in_op;
  logic [1:0] in_op2;
  logic [2:0] in_waddr;
  logic [7:0] in_result;
  logic       in_carry;
  logic       in_ovf;
  logic       in_zero;
  logic       flag_clr;
  logic       carry_flag;
  logic       ovf_flag;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_waddr;
  logic [7:0] wb_wdata;
  logic       branch_taken;
  logic       illegal;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [10:0] sb [$];

  alu_writeback #(.DW(8), .AW(3)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ritype(in_ritype), .in_op(in_op), .in_op2(in_op2),
    .in_waddr(in_waddr), .in_result(in_result), .in_carry(in_carry),
    .in_ovf(in_ovf), .in_zero(in_zero), .flag_clr(flag_clr),
    .carry_flag(carry_flag), .ovf_flag(ovf_flag), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 Clk = ~Clk;

  // Scoreboard: every pop seen at the falling edge must match the oldest expected write.
  always @(negedge Clk) begin
    if (!Reset && wb_valid && wb_ready) begin
      logic [10:0] exp_e;
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got addr=%0d data=%02h expected none", wb_waddr, wb_wdata);
      end else begin
        exp_e = sb.pop_front();
        if ({wb_waddr, wb_wdata} !== exp_e) begin
          errors++;
          $display("FAIL pop_data got addr=%0d data=%02h expected addr=%0d data=%02h",
                   wb_waddr, wb_wdata, exp_e[10:8], exp_e[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flag_clr = 1'b0;
  endtask

  // Present one instruction; exp_push records the write it should queue.
  task automatic issue(input logic rit, input logic [2:0] op, input logic [1:0] op2,
                       input logic [2:0] wa, input logic [7:0] res,
                       input logic c, input logic v, input logic z, input logic exp_push);
    in_valid  = 1'b1;
    in_ritype = rit;
    in_op     = op;
    in_op2    = op2;
    in_waddr  = wa;
    in_result = res;
    in_carry  = c;
    in_ovf    = v;
    in_zero   = z;
    if (exp_push) sb.push_back({wa, res});
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle(); wb_ready = 1'b0;
    in_ritype = 1'b0; in_op = '0; in_op2 = '0; in_waddr = '0; in_result = '0;
    in_carry = 1'b0; in_ovf = 1'b0; in_zero = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
    checks++;
    if ({wb_valid, carry_flag, ovf_flag, branch_taken, illegal} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b c=%b o=%b br=%b il=%b expected all 0",
               wb_valid, carry_flag, ovf_flag, branch_taken, illegal);
    end
    checks++;
    if ({wb_waddr, wb_wdata} !== 11'h0) begin
      errors++; $display("FAIL reset_head got %0d/%02h expected 0/00", wb_waddr, wb_wdata);
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    wb_ready = 1'b1;
    issue(1'b0, 3'b001, 2'b00, 3'd3, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1);
    step(); idle();
    checks++;
    if ({carry_flag, ovf_flag} !== 2'b01) begin
      errors++; $display("FAIL add_flags got c=%b v=%b expected c=0 v=1", carry_flag, ovf_flag);
    end
    checks++;
    if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 3'd3, 8'h05}) begin
      errors++; $display("FAIL add_head got v=%b %0d/%02h expected v=1 3/05", wb_valid, wb_waddr, wb_wdata);
    end
    step();
    checks++;
    if ({wb_valid, wb_waddr, wb_wdata} !== {1'b0, 3'd3, 8'h05}) begin
      errors++; $display("FAIL add_drained got v=%b %0d/%02h expected v=0 3/05", wb_valid, wb_waddr, wb_wdata);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL empty_no_underflow got %b expected 0", wb_valid); end
  endtask

  task automatic test_fill();
    int p0;
    p0 = pops;
    wb_ready = 1'b0;
    issue(1'b0, 3'b000, 2'b00, 3'd1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_one_ready got %b expected 1", in_ready); end
    issue(1'b0, 3'b011, 2'b00, 3'd2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %b expected 0", in_ready); end
    issue(1'b0, 3'b100, 2'b00, 3'd3, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if ({in_ready, wb_valid, wb_waddr, wb_wdata} !== {1'b0, 1'b1, 3'd1, 8'h11}) begin
      errors++; $display("FAIL fill_held got rdy=%b v=%b %0d/%02h expected rdy=0 v=1 1/11",
                         in_ready, wb_valid, wb_waddr, wb_wdata);
    end
    wb_ready = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back got %b expected 1", in_ready); end
    sb.push_back({3'd3, 8'h33});
    step(); idle();
    for (int i = 0; i < 6 && wb_valid; i++) step();
    checks++;
    if (wb_valid !== 1'b0 || sb.size() != 0 || pops - p0 != 3) begin
      errors++; $display("FAIL fill_drain got v=%b left=%0d pops=%0d expected v=0 left=0 pops=3",
                         wb_valid, sb.size(), pops - p0);
    end
  endtask

  task automatic test_branch();
    issue(1'b1, 3'b000, 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checks++;
    if ({branch_taken, wb_valid} !== 2'b10) begin
      errors++; $display("FAIL beqz_taken got br=%b v=%b expected br=1 v=0", branch_taken, wb_valid);
    end
    issue(1'b1, 3'b000, 2'b00, 3'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); idle();
    checks++;
    if ({branch_taken, wb_valid} !== 2'b00) begin
      errors++; $display("FAIL beqz_not_taken got br=%b v=%b expected br=0 v=0", branch_taken, wb_valid);
    end
    step();
    checks++;
    if (branch_taken !== 1'b0) begin errors++; $display("FAIL beqz_idle got %b expected 0", branch_taken); end
  endtask

  task automatic test_flags();
    issue(1'b0, 3'b001, 2'b00, 3'd4, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    checks++;
    if ({carry_flag, ovf_flag} !== 2'b01) begin
      errors++; $display("FAIL add_keeps_c got c=%b v=%b expected c=0 v=1", carry_flag, ovf_flag);
    end
    issue(1'b0, 3'b101, 2'b00, 3'd5, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    checks++;
    if ({carry_flag, ovf_flag} !== 2'b10) begin
      errors++; $display("FAIL shift_clr got c=%b v=%b expected c=1 v=0", carry_flag, ovf_flag);
    end
    issue(1'b0, 3'b110, 2'b00, 3'd6, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    checks++;
    if ({carry_flag, ovf_flag} !== 2'b10) begin
      errors++; $display("FAIL gt_holds got c=%b v=%b expected c=1 v=0", carry_flag, ovf_flag);
    end
    idle(); flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    checks++;
    if ({carry_flag, ovf_flag} !== 2'b00) begin
      errors++; $display("FAIL clr_only got c=%b v=%b expected c=0 v=0", carry_flag, ovf_flag);
    end
    for (int i = 0; i < 4 && wb_valid; i++) step();
  endtask

  task automatic test_illegal();
    issue(1'b0, 3'b101, 2'b00, 3'd7, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); idle(); step();
    issue(1'b0, 3'b111, 2'b00, 3'd2, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++;
    if ({illegal, carry_flag, ovf_flag, wb_valid} !== 4'b1100) begin
      errors++; $display("FAIL ill_r111 got il=%b c=%b v=%b wv=%b expected il=1 c=1 v=0 wv=0",
                         illegal, carry_flag, ovf_flag, wb_valid);
    end
    issue(1'b1, 3'b001, 2'b11, 3'd2, 8'hBB, 1'b0, 1'b1, 1'b0, 1'b0);
    step(); idle();
    checks++;
    if ({illegal, carry_flag, ovf_flag, wb_valid} !== 4'b1100) begin
      errors++; $display("FAIL ill_i11 got il=%b c=%b v=%b wv=%b expected il=1 c=1 v=0 wv=0",
                         illegal, carry_flag, ovf_flag, wb_valid);
    end
    step();
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL ill_idle got %b expected 0", illegal); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [4];
    ops[0] = 3'b010; ops[1] = 3'b011; ops[2] = 3'b100; ops[3] = 3'b000;
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4)
        issue(1'b1, 3'b000, 2'b01, 3'd4, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b1);
      else
        issue(1'b0, ops[i], 2'b00, 3'(i), 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      checks++;
      if ({in_ready, wb_valid} !== 2'b11) begin
        errors++; $display("FAIL b2b_stream_%0d got rdy=%b v=%b expected 1 1", i, in_ready, wb_valid);
      end
    end
    idle();
    for (int i = 0; i < 4 && wb_valid; i++) step();
    checks++;
    if (wb_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain got v=%b left=%0d expected v=0 left=0", wb_valid, sb.size());
    end
  endtask

  task automatic test_mid_reset();
    wb_ready = 1'b0;
    issue(1'b0, 3'b001, 2'b00, 3'd4, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    issue(1'b0, 3'b101, 2'b00, 3'd5, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
    step(); idle();
    checks++;
    if ({wb_valid, carry_flag, ovf_flag, in_ready} !== 4'b1110) begin
      errors++; $display("FAIL mr_setup got v=%b c=%b o=%b rdy=%b expected 1 1 1 0",
                         wb_valid, carry_flag, ovf_flag, in_ready);
    end
    #2 Reset = 1'b1;
    #1;
    sb.delete();
    checks++;
    if ({wb_valid, carry_flag, ovf_flag, branch_taken, illegal, in_ready} !== 6'b0) begin
      errors++; $display("FAIL mr_async got v=%b c=%b o=%b br=%b il=%b rdy=%b expected all 0",
                         wb_valid, carry_flag, ovf_flag, branch_taken, illegal, in_ready);
    end
    step();
    Reset = 1'b0;
    wb_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, wb_valid} !== 2'b10) begin
      errors++; $display("FAIL mr_release got rdy=%b v=%b expected 1 0", in_ready, wb_valid);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL mr_empty got %b expected 0", wb_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fill();
    test_branch();
    test_flags();
    test_illegal();
    test_back_to_back();
    test_mid_reset();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
